// File: rtl/profile_sample_ctrl.sv
// Profile counter sequencer with a periodic sampler and a sample FIFO that is drained by POP commands.
// Define PROFILE_SAMPLE_IRQ_EN to add the irq_o output (FIFO half-full or overflow).
module profile_sample_ctrl #(
    parameter logic [7:0] customId   = 8'h00,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [7:0]  ciN_i,
    input  logic [31:0] valueA_i,
    input  logic [31:0] valueB_i,
    output logic        done_o,
    output logic [31:0] result_o,
    input  logic [31:0] counterValue0_i,
    input  logic [31:0] counterValue1_i,
    input  logic [31:0] counterValue2_i,
    output logic [2:0]  counterEnable_o,
    output logic [2:0]  counterClear_o
`ifdef PROFILE_SAMPLE_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [2:0] OP_STATUS     = 3'd0;
    localparam logic [2:0] OP_SET_MASK   = 3'd1;
    localparam logic [2:0] OP_CLEAR      = 3'd2;
    localparam logic [2:0] OP_SET_PERIOD = 3'd3;
    localparam logic [2:0] OP_START      = 3'd4;
    localparam logic [2:0] OP_STOP       = 3'd5;
    localparam logic [2:0] OP_POP        = 3'd6;
    localparam logic [2:0] OP_SET_SEL    = 3'd7;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    logic [2:0]     mask_q, mask_d;
    logic [31:0]    period_q, period_d;
    logic [1:0]     sel_q, sel_d;
    logic [31:0]    timer_q, timer_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;
    logic           done_q, done_d;
    logic [31:0]    result_q, result_d;
    logic [2:0]     enable_q, enable_d;
    logic [2:0]     clear_q, clear_d;
    logic           irq_q, irq_d;

    logic [31:0]    mem [FIFO_DEPTH];
    logic           accept, push, pop, push_ok, full, empty;
    logic [2:0]     op;
    logic [31:0]    sample;
    logic [7:0]     count8;
    logic           unused_bits;

    assign unused_bits = ^valueA_i[31:3];

    always_comb begin
        accept   = start_i && (ciN_i == customId);
        op       = valueA_i[2:0];
        full     = (count_q == CW'(FIFO_DEPTH));
        empty    = (count_q == '0);
        count8   = 8'(count_q);
        state_d  = state_q;
        mask_d   = mask_q;
        period_d = period_q;
        sel_d    = sel_q;
        timer_d  = timer_q;
        ovf_d    = ovf_q;
        done_d   = accept;
        result_d = '0;
        clear_d  = '0;
        push     = 1'b0;

        case (sel_q)
            2'd1:    sample = counterValue1_i;
            2'd2:    sample = counterValue2_i;
            default: sample = counterValue0_i;
        endcase

        // The sampler looks at the current state, so a STOP on the terminal edge still pushes.
        if (state_q == RUN && period_q != '0) begin
            if (timer_q == '0) begin
                push    = 1'b1;
                timer_d = period_q - 32'd1;
            end else begin
                timer_d = timer_q - 32'd1;
            end
        end

        pop = accept && (op == OP_POP) && !empty;

        if (accept) begin
            case (op)
                OP_STATUS:     result_d = {16'b0, count8, 4'b0, full, empty, ovf_q, state_q == RUN};
                OP_SET_MASK:   mask_d = valueB_i[2:0];
                OP_CLEAR: begin
                    clear_d = valueB_i[2:0];
                    if (valueB_i[31]) ovf_d = 1'b0;
                end
                OP_SET_PERIOD: period_d = valueB_i;
                OP_START: begin
                    if (state_q == IDLE) begin
                        state_d = RUN;
                        timer_d = period_q - 32'd1;
                    end
                end
                OP_STOP:       if (state_q == RUN) state_d = IDLE;
                OP_POP:        if (!empty) result_d = mem[rd_ptr_q];
                OP_SET_SEL:    sel_d = valueB_i[1:0];
                default:       result_d = '0;
            endcase
        end

        // A dropped sample wins over a same-edge overflow clear.
        push_ok = push && (!full || pop);
        if (push && full && !pop) ovf_d = 1'b1;

        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        if (push_ok && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push_ok) count_d = count_q - CW'(1);
        else                      count_d = count_q;

        enable_d = (state_q == RUN) ? mask_q : 3'b000;
        irq_d    = (count_q >= CW'(FIFO_DEPTH / 2)) || ovf_q;
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            period_q <= '0;
            sel_q    <= '0;
            timer_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            enable_q <= '0;
            clear_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            period_q <= period_d;
            sel_q    <= sel_d;
            timer_q  <= timer_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            result_q <= result_d;
            enable_q <= enable_d;
            clear_q  <= clear_d;
            irq_q    <= irq_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (push_ok) mem[wr_ptr_q] <= sample;
    end

    assign done_o          = done_q;
    assign result_o        = result_q;
    assign counterEnable_o = enable_q;
    assign counterClear_o  = clear_q;
`ifdef PROFILE_SAMPLE_IRQ_EN
    assign irq_o           = irq_q;
`else
    logic unused_irq;
    assign unused_irq = irq_q ^ unused_bits;
`endif
`ifdef PROFILE_SAMPLE_IRQ_EN
    logic unused_misc;
    assign unused_misc = unused_bits;
`endif

endmodule

// File: tb/tb_profile_sample_ctrl.sv
// Directed bench for profile_sample_ctrl: commands push expected results to a scoreboard queue,
// a monitor pops and compares whenever done_o is seen.
module tb_profile_sample_ctrl;

    localparam logic [7:0] ID = 8'h2A;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  ci_n = 8'h00;
    logic [31:0] va = '0;
    logic [31:0] vb = '0;
    logic        done;
    logic [31:0] result;
    logic [31:0] cv0, cv1, cv2;
    logic [2:0]  en, clr;
    logic [31:0] cyc = '0;
`ifdef PROFILE_SAMPLE_IRQ_EN
    logic        irq;
`endif

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] s;

    profile_sample_ctrl #(.customId(ID), .FIFO_DEPTH(8)) dut (
        .clock_i(clk), .reset_i(rst_n), .start_i(start), .ciN_i(ci_n),
        .valueA_i(va), .valueB_i(vb), .done_o(done), .result_o(result),
        .counterValue0_i(cv0), .counterValue1_i(cv1), .counterValue2_i(cv2),
        .counterEnable_o(en), .counterClear_o(clr)
`ifdef PROFILE_SAMPLE_IRQ_EN
        , .irq_o(irq)
`endif
    );

    always #5 clk = ~clk;
    always @(negedge clk) cyc <= cyc + 32'd1;
    assign cv0 = cyc;
    assign cv1 = cyc ^ 32'hA5A5_0000;
    assign cv2 = cyc + 32'h1000_0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ci(input logic [2:0] op, input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk); #1;
        start = 1'b1; ci_n = ID; va = {29'h0, op}; vb = b;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0;
        $display("cmd op=%0d b=%h expect=%h", op, b, exp);
    endtask

    always @(posedge clk) begin
        #1;
        if (done) begin
            if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else chk("ci_result", result, exp_q.pop_front());
        end else begin
            chk("idle_result", result, 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_enable", {29'b0, en}, 32'd0);
        chk("rst_clear", {29'b0, clr}, 32'd0);
`ifdef PROFILE_SAMPLE_IRQ_EN
        chk("rst_irq", {31'b0, irq}, 32'd0);
`endif
        @(negedge clk) rst_n = 1'b1;

        ci(3'd0, 32'h0, 32'h0000_0004);

        // Command to another CI number must be ignored.
        @(negedge clk); #1;
        start = 1'b1; ci_n = 8'h00; va = '0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("foreign_ci_no_done", {31'b0, done}, 32'd0);

        // Enable follows mask one cycle after the RUN edge.
        ci(3'd1, 32'h3, 32'h0);
        ci(3'd4, 32'h0, 32'h0);
        chk("enable_lag", {29'b0, en}, 32'd0);
        @(posedge clk); #1;
        chk("enable_run", {29'b0, en}, 32'd3);
        ci(3'd0, 32'h0, 32'h0000_0005);
        ci(3'd5, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("enable_stop", {29'b0, en}, 32'd0);

        // Period 4 sampling of the cycle counter.
        ci(3'd3, 32'd4, 32'h0);
        ci(3'd7, 32'd0, 32'h0);
        ci(3'd4, 32'h0, 32'h0);
        s = cyc;
        repeat (10) @(posedge clk);
        ci(3'd5, 32'h0, 32'h0);
        ci(3'd0, 32'h0, 32'h0000_0200);
        ci(3'd6, 32'h0, s + 32'd4);
        ci(3'd6, 32'h0, s + 32'd8);
        ci(3'd6, 32'h0, 32'h0);
        ci(3'd0, 32'h0, 32'h0000_0004);

        // STOP coinciding with the terminal timer edge still pushes, then the timer freezes.
        ci(3'd7, 32'd2, 32'h0);
        ci(3'd4, 32'h0, 32'h0);
        s = cyc;
        repeat (3) @(posedge clk);
        ci(3'd5, 32'h0, 32'h0);
        ci(3'd0, 32'h0, 32'h0000_0100);
        repeat (8) @(posedge clk);
        ci(3'd0, 32'h0, 32'h0000_0100);
        ci(3'd6, 32'h0, s + 32'd4 + 32'h1000_0000);
        ci(3'd0, 32'h0, 32'h0000_0004);

        // Period 1 with no draining: fill, overflow, then clear overflow.
        ci(3'd3, 32'd1, 32'h0);
        ci(3'd7, 32'd3, 32'h0);
        ci(3'd4, 32'h0, 32'h0);
        s = cyc;
        repeat (20) @(posedge clk);
        ci(3'd0, 32'h0, 32'h0000_080B);
        ci(3'd5, 32'h0, 32'h0);
        ci(3'd2, 32'h8000_0000, 32'h0);
        ci(3'd0, 32'h0, 32'h0000_0808);
`ifdef PROFILE_SAMPLE_IRQ_EN
        @(posedge clk); #1;
        chk("irq_full", {31'b0, irq}, 32'd1);
`endif

        // Full FIFO: POP on the same edge as a push keeps count and raises no overflow.
        ci(3'd3, 32'd4, 32'h0);
        ci(3'd4, 32'h0, 32'h0);
        begin
            logic [31:0] s5;
            s5 = cyc;
            repeat (3) @(posedge clk);
            ci(3'd6, 32'h0, s + 32'd1);
            ci(3'd5, 32'h0, 32'h0);
            ci(3'd0, 32'h0, 32'h0000_0808);
            for (int k = 2; k <= 8; k++) ci(3'd6, 32'h0, s + 32'(k));
            ci(3'd6, 32'h0, s5 + 32'd4);
        end
        ci(3'd6, 32'h0, 32'h0);
        ci(3'd0, 32'h0, 32'h0000_0004);

        // Clear pulse lasts exactly one cycle.
        ci(3'd2, 32'h0000_0005, 32'h0);
        chk("clear_pulse", {29'b0, clr}, 32'd5);
        @(posedge clk); #1;
        chk("clear_gone", {29'b0, clr}, 32'd0);

        // Asynchronous reset in the middle of RUN.
        ci(3'd1, 32'h7, 32'h0);
        ci(3'd3, 32'd2, 32'h0);
        ci(3'd4, 32'h0, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        chk("enable_all", {29'b0, en}, 32'd7);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_enable", {29'b0, en}, 32'd0);
        chk("mid_rst_clear", {29'b0, clr}, 32'd0);
`ifdef PROFILE_SAMPLE_IRQ_EN
        chk("mid_rst_irq", {31'b0, irq}, 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        ci(3'd0, 32'h0, 32'h0000_0004);
        ci(3'd4, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("mask_after_rst", {29'b0, en}, 32'd0);
        ci(3'd0, 32'h0, 32'h0000_0005);

        @(posedge clk); #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
